// File: rtl/sampler_pkg.sv
// Shared sampler types: recorder state encoding, default widths and
// the RAM half-select convention used by record and playback.
package sampler_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 15;

  // MSB of a RAM address selects the channel half.
  localparam logic SEL_LEFT  = 1'b0;
  localparam logic SEL_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } rec_state_e;

endpackage

// File: rtl/sample_abs_compare.sv
// Flags a stereo frame whose left or right magnitude reaches the
// trigger level; the most negative code saturates to max positive.
module sample_abs_compare #(
  parameter int                DATA_W     = 24,
  parameter logic [DATA_W-1:0] TRIG_LEVEL = DATA_W'(4096)
) (
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_hit
);

  localparam logic [DATA_W-1:0] MIN_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS =
    {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic [DATA_W-1:0] mag(
    input logic [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] m;
    m = x;
    if (x[DATA_W-1]) begin
      m = (x == MIN_NEG) ? MAX_POS : -x;
    end
    return m;
  endfunction

  logic w_left_hit;
  logic w_right_hit;

  assign w_left_hit  = mag(i_left) >= TRIG_LEVEL;
  assign w_right_hit = mag(i_right) >= TRIG_LEVEL;
  assign o_hit       = w_left_hit | w_right_hit;

endmodule

// File: rtl/sample_recorder.sv
// Codec-to-RAM stereo capture: left to the lower RAM half, right to the
// upper half. SAMPLE_RECORDER_TRIGGER_EN enables level-triggered start.
module sample_recorder
  import sampler_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] TRIG_LEVEL = DATA_W'(4096)
) (
  input  logic              clk,
  input  logic              clear_b,
  input  logic              rec_EN,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] left_channel_audio_in,
  input  logic [DATA_W-1:0] right_channel_audio_in,
  output logic              read,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_a,
  output logic              wren_b,
  output logic              rec_busy,
  output logic              rec_done,
  output logic [ADDR_W-1:0] sample_len
);

  localparam int CNT_W = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] FULL_LEN =
    ADDR_W'(1) << CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  rec_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic              r_read;
  logic              r_wren;

  logic w_take;
  logic w_wr;
  logic w_start;

  assign w_start = (r_state == S_IDLE) & rec_EN;

`ifdef SAMPLE_RECORDER_TRIGGER_EN
  logic w_hit;
  logic r_hit;

  sample_abs_compare #(
    .DATA_W     (DATA_W),
    .TRIG_LEVEL (TRIG_LEVEL)
  ) u_cmp (
    .i_left  (left_channel_audio_in),
    .i_right (right_channel_audio_in),
    .o_hit   (w_hit)
  );

  // ARM pops frames too; only a frame above threshold is written.
  assign w_take = rec_EN & read_ready &
                  ((r_state == S_CAPTURE) |
                   (r_state == S_ARM));
  assign w_wr   = (r_state == S_CAPTURE) | w_hit;

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      r_hit <= 1'b0;
    end else if (w_start) begin
      r_hit <= 1'b0;
    end else if (w_take && r_state == S_ARM && w_hit) begin
      r_hit <= 1'b1;
    end
  end
`else
  logic w_unused_trig;
  assign w_unused_trig = ^TRIG_LEVEL;

  assign w_take = rec_EN & read_ready &
                  (r_state == S_CAPTURE);
  assign w_wr   = 1'b1;
`endif

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (rec_EN) r_state <= S_ARM;
        end
        S_ARM: begin
          if (!rec_EN) begin
            r_state <= S_DONE;
`ifdef SAMPLE_RECORDER_TRIGGER_EN
          end else if (read_ready) begin
            r_state <= S_WRITE;
`else
          end else begin
            r_state <= S_CAPTURE;
`endif
          end
        end
        S_CAPTURE: begin
          if (!rec_EN) begin
            r_state <= S_DONE;
          end else if (read_ready) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_wren && r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (!rec_EN) begin
            r_state <= S_DONE;
          end else begin
`ifdef SAMPLE_RECORDER_TRIGGER_EN
            r_state <= r_hit ? S_CAPTURE : S_ARM;
`else
            r_state <= S_CAPTURE;
`endif
          end
        end
        S_DONE: begin
          if (!rec_EN) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes live for exactly the WRITE cycle after a take.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      r_read   <= 1'b0;
      r_wren   <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (w_take) begin
      r_read   <= 1'b1;
      r_wren   <= w_wr;
      r_addr_a <= {SEL_LEFT, r_cnt};
      r_addr_b <= {SEL_RIGHT, r_cnt};
      r_data_a <= left_channel_audio_in;
      r_data_b <= right_channel_audio_in;
    end else begin
      r_read <= 1'b0;
      r_wren <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      r_cnt <= '0;
      r_len <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_len <= '0;
    end else if (r_state == S_WRITE && r_wren) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_len != FULL_LEN) r_len <= r_len + 1'b1;
    end
  end

  assign read       = r_read;
  assign wren_a     = r_wren;
  assign wren_b     = r_wren;
  assign address_a  = r_addr_a;
  assign address_b  = r_addr_b;
  assign data_a     = r_data_a;
  assign data_b     = r_data_b;
  assign sample_len = r_len;
  assign rec_done   = (r_state == S_DONE);
  assign rec_busy   = (r_state == S_ARM) |
                      (r_state == S_CAPTURE) |
                      (r_state == S_WRITE) |
                      (r_state == S_GAP);

endmodule

// File: tb/tb_sample_recorder.sv
// Directed bench for sample_recorder with a frame-queue reference model
// and a per-cycle compare process on the RAM write side.
module tb_sample_recorder;

  localparam int AW = 15;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          clear_b = 1'b0;
  logic          rec_EN = 1'b0;
  logic          read_ready = 1'b0;
  logic [DW-1:0] lin = '0;
  logic [DW-1:0] rin = '0;
  logic          read;
  logic [AW-1:0] address_a;
  logic [AW-1:0] address_b;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          wren_a;
  logic          wren_b;
  logic          rec_busy;
  logic          rec_done;
  logic [AW-1:0] sample_len;

  sample_recorder dut (
    .clk                    (clk),
    .clear_b                (clear_b),
    .rec_EN                 (rec_EN),
    .read_ready             (read_ready),
    .left_channel_audio_in  (lin),
    .right_channel_audio_in (rin),
    .read                   (read),
    .address_a              (address_a),
    .address_b              (address_b),
    .data_a                 (data_a),
    .data_b                 (data_b),
    .wren_a                 (wren_a),
    .wren_b                 (wren_b),
    .rec_busy               (rec_busy),
    .rec_done               (rec_done),
    .sample_len             (sample_len)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } ev_t;

  ev_t           q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_wr = 0;
  int            n_rd = 0;
  int            m_wr_count = 0;
  bit            m_trig = 1'b0;
  bit            prev_wren = 1'b0;
  logic [AW-1:0] last_a = '0;
  logic [AW-1:0] last_b = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit over_level(input logic [DW-1:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = (v == -8388608) ? 8388607 : -v;
    return v >= 4096;
  endfunction

  // Model: each popped frame is written at the next free slot once
  // recording has started; RAM holds 16384 frames per channel.
  task automatic push(input logic [DW-1:0] l,
                      input logic [DW-1:0] r);
    ev_t e;
    bit  h;
`ifdef SAMPLE_RECORDER_TRIGGER_EN
    h = m_trig || over_level(l) || over_level(r);
`else
    h = 1'b1;
`endif
    e.wr   = h;
    e.addr = h ? AW'(m_wr_count) : '0;
    e.l    = l;
    e.r    = r;
    if (h) begin
      m_trig = 1'b1;
      m_wr_count++;
    end
    q.push_back(e);
  endtask

  task automatic present(input logic [DW-1:0] l,
                         input logic [DW-1:0] r);
    bit got;
    got = 1'b0;
    push(l, r);
    lin = l;
    rin = r;
    read_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (read) begin
        got = 1'b1;
        break;
      end
    end
    read_ready = 1'b0;
    if (!got) chk("read_timeout", 64'(read), 64'd1);
  endtask

  task automatic start_take();
    m_wr_count = 0;
    m_trig = 1'b0;
    n_wr = 0;
    n_rd = 0;
    rec_EN = 1'b1;
  endtask

  task automatic end_take();
    bit seen;
    rec_EN = 1'b0;
    seen = rec_done;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = rec_done;
    end
    chk("done_reached", 64'(seen), 64'd1);
    chk("busy_in_done", 64'(rec_busy), 64'd0);
    chk("len_model", 64'(sample_len), 64'(m_wr_count));
    chk("queue_drained", 64'(q.size()), 64'd0);
    @(negedge clk);
    #1;
    chk("idle_after_done", 64'(rec_done), 64'd0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (clear_b) begin
      chk("wren_pair", 64'(wren_b), 64'(wren_a));
      if (wren_a) chk("back_to_back", 64'(prev_wren), 64'd0);
      if (read) begin
        n_rd++;
        if (q.size() == 0) begin
          chk("read_unexpected", 64'(read), 64'd0);
        end else begin
          e = q.pop_front();
          chk("wren_vs_model", 64'(wren_a), 64'(e.wr));
          if (e.wr) begin
            n_wr++;
            chk("addr_a", 64'(address_a), 64'({1'b0, e.addr[AW-2:0]}));
            chk("addr_b", 64'(address_b), 64'({1'b1, e.addr[AW-2:0]}));
            chk("data_a", 64'(data_a), 64'(e.l));
            chk("data_b", 64'(data_b), 64'(e.r));
            last_a = address_a;
            last_b = address_b;
          end
        end
      end else begin
        chk("wren_without_read", 64'(wren_a), 64'd0);
      end
      prev_wren = wren_a;
    end
  end

  initial begin
    #2500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] v;
    int          rd0;
    repeat (3) @(negedge clk);
    clear_b = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_read", 64'(read), 64'd0);
    chk("rst_wren_a", 64'(wren_a), 64'd0);
    chk("rst_wren_b", 64'(wren_b), 64'd0);
    chk("rst_addr_a", 64'(address_a), 64'd0);
    chk("rst_addr_b", 64'(address_b), 64'd0);
    chk("rst_data_a", 64'(data_a), 64'd0);
    chk("rst_data_b", 64'(data_b), 64'd0);
    chk("rst_len", 64'(sample_len), 64'd0);
    chk("rst_busy", 64'(rec_busy), 64'd0);
    chk("rst_done", 64'(rec_done), 64'd0);

    // three single frames
    start_take();
    present(24'h000111, 24'h000222);
    repeat (2) @(negedge clk);
    present(24'h000333, 24'h000444);
    repeat (2) @(negedge clk);
    present(24'h000555, 24'h000666);
    repeat (2) @(negedge clk);
    end_take();
    chk("three_reads", 64'(n_rd), 64'd3);
`ifndef SAMPLE_RECORDER_TRIGGER_EN
    chk("three_writes", 64'(n_wr), 64'd3);
    chk("three_len", 64'(sample_len), 64'd3);
    chk("three_last_a", 64'(last_a), 64'd2);
    chk("three_last_b", 64'(last_b), 64'd16386);
`endif

    // read_ready held for 10 cycles from the take start
    start_take();
    repeat (3) push(24'h100000, 24'h200000);
    lin = 24'h100000;
    rin = 24'h200000;
    read_ready = 1'b1;
    repeat (10) @(negedge clk);
    read_ready = 1'b0;
    repeat (3) @(negedge clk);
    end_take();
    chk("held_writes", 64'(n_wr), 64'd3);
    chk("held_len", 64'(sample_len), 64'd3);

    // fill the RAM
    start_take();
    for (int i = 0; i < 16384; i++) begin
      v = 20'(i);
      present({4'h1, v}, {4'h2, ~v});
    end
    repeat (2) @(negedge clk);
    rd0 = n_rd;
    lin = 24'h123456;
    rin = 24'h654321;
    read_ready = 1'b1;
    repeat (10) @(negedge clk);
    read_ready = 1'b0;
    #1;
    chk("full_no_read", 64'(n_rd), 64'(rd0));
    chk("full_done_held", 64'(rec_done), 64'd1);
    chk("full_last_a", 64'(last_a), 64'd16383);
    chk("full_last_b", 64'(last_b), 64'd32767);
    chk("full_len", 64'(sample_len), 64'd16384);
    chk("full_writes", 64'(n_wr), 64'd16384);
    end_take();

    // reset during the write cycle of frame 5
    start_take();
    for (int i = 0; i < 5; i++) begin
      present(24'h010000 + 24'(i), 24'h020000 + 24'(i));
    end
    clear_b = 1'b0;
    #1;
    chk("midrst_wren_a", 64'(wren_a), 64'd0);
    chk("midrst_wren_b", 64'(wren_b), 64'd0);
    chk("midrst_read", 64'(read), 64'd0);
    chk("midrst_len", 64'(sample_len), 64'd0);
    chk("midrst_busy", 64'(rec_busy), 64'd0);
    chk("midrst_done", 64'(rec_done), 64'd0);
    rec_EN = 1'b0;
    @(negedge clk);
    clear_b = 1'b1;
    chk("midrst_queue", 64'(q.size()), 64'd0);
    m_wr_count = 0;
    repeat (2) @(negedge clk);

`ifdef SAMPLE_RECORDER_TRIGGER_EN
    start_take();
    present(24'd100, 24'hFFFF38);
    repeat (2) @(negedge clk);
    present(24'hFFF001, 24'h000FFF);
    repeat (2) @(negedge clk);
    present(24'hFFEC78, 24'd0);
    repeat (2) @(negedge clk);
    end_take();
    chk("trig_reads", 64'(n_rd), 64'd3);
    chk("trig_writes", 64'(n_wr), 64'd1);
    chk("trig_len", 64'(sample_len), 64'd1);
    chk("trig_addr", 64'(last_a), 64'd0);
    chk("trig_data", 64'(data_a), 64'hFFEC78);

    start_take();
    present(24'h800000, 24'd0);
    repeat (2) @(negedge clk);
    end_take();
    chk("trig_min_len", 64'(sample_len), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_recorder.md
Name: sample_recorder

Overview:
- Capture side of the sampler: takes stereo 24-bit frames from the audio codec read FIFO and writes them into the dual-port ram_24bit_audio sample RAM.
- Left channel is written through port a into the lower half of the RAM; right channel through port b into the upper half.
- Sits between the codec read interface (read_ready/read) and the RAM write ports; the playback path reads the same layout back.

Parameters:
- ADDR_W, 15, RAM address width; frames per channel = 2^(ADDR_W-1).
- DATA_W, 24, sample width.
- TRIG_LEVEL, 24'd4096, trigger magnitude threshold (used only with the optional feature).

Ports:
- clk  in  1  system clock (50 MHz).
- clear_b  in  1  asynchronous active-low reset.
- rec_EN  in  1  record request; level-sensitive.
- read_ready  in  1  codec has a frame available.
- left_channel_audio_in  in  DATA_W  codec left sample, two's complement.
- right_channel_audio_in  in  DATA_W  codec right sample, two's complement.
- read  out  1  one-cycle pop strobe to the codec.
- address_a  out  ADDR_W  RAM port a address (left channel).
- address_b  out  ADDR_W  RAM port b address (right channel).
- data_a  out  DATA_W  left write data.
- data_b  out  DATA_W  right write data.
- wren_a  out  1  port a write enable.
- wren_b  out  1  port b write enable.
- rec_busy  out  1  high in ARM, CAPTURE, WRITE and GAP.
- rec_done  out  1  high in DONE.
- sample_len  out  ADDR_W  number of frames written in the last or current take.

Behaviour:
- Clock and reset: single clock clk; clear_b is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - All outputs 0, including addresses, data, sample_len and the internal frame counter cnt (ADDR_W-1 bits).
- Reset mid-operation: clear_b low in any state aborts the take immediately. No partial write is asserted afterwards.
- IDLE:
  - rec_EN=1 moves to ARM on the next edge.
  - cnt and sample_len clear to 0 on that same edge.
- ARM:
  - Without the feature: one cycle, then CAPTURE.
  - rec_EN=0 in ARM moves to DONE.
- CAPTURE:
  - rec_EN=0 moves to DONE; it takes priority over read_ready on the same edge.
  - Otherwise read_ready=1 latches both channel inputs into data_a and data_b, sets read<=1, and moves to WRITE.
- WRITE (exactly one cycle):
  - read=1, wren_a=1, wren_b=1.
  - address_a = {1'b0,cnt}; address_b = {1'b1,cnt}.
  - On exit: read<=0, wren<=0, cnt<=cnt+1, sample_len<=sample_len+1.
  - If cnt was 2^(ADDR_W-1)-1 (RAM full), go to DONE with no wrap-around. Otherwise go to GAP.
- GAP:
  - One cycle during which read_ready is ignored, so the codec can deassert it; then CAPTURE.
  - rec_EN low during WRITE or GAP: the in-flight frame still completes, then the block goes to DONE.
- Latency: read_ready sampled high at edge N gives read, wren_a/b, address and data all valid in cycle N+1. Minimum frame spacing is 3 cycles.
- DONE:
  - rec_done=1; sample_len holds.
  - Moves to IDLE only when rec_EN=0, so a new take needs rec_EN low then high again.
- data_a/data_b hold their last value outside WRITE. Addresses also hold but are don't-care while wren is low.
- sample_len saturates at 2^(ADDR_W-1).

Optional Feature:
- Macro: SAMPLE_RECORDER_TRIGGER_EN.
- Defined:
  - ARM pops codec frames using the same read/GAP handshake but discards them (no wren) until |left| >= TRIG_LEVEL or |right| >= TRIG_LEVEL.
  - Magnitude is the two's-complement absolute value; -2^(DATA_W-1) maps to 2^(DATA_W-1)-1.
  - The triggering frame is written as frame 0, then normal CAPTURE follows.
- Undefined: ARM passes straight to CAPTURE with no threshold; TRIG_LEVEL is unused.

Decomposition:
- Shared package sampler_pkg holds:
  - the state enum (IDLE, ARM, CAPTURE, WRITE, GAP, DONE);
  - DATA_W and ADDR_W defaults;
  - the left/right half-select bit convention (0 = left, 1 = right), shared with the playback counters.
- One sub-module, sample_abs_compare: combinational magnitude-vs-threshold check. It is instantiated only under SAMPLE_RECORDER_TRIGGER_EN.

Test Plan:
- Reset values: clear_b low, then high with rec_EN=0 -> all outputs 0, rec_busy=0, rec_done=0.
- Three-frame take: rec_EN=1; three read_ready pulses with L=24'h000111/R=24'h000222, L=24'h000333/R=24'h000444, L=24'h000555/R=24'h000666; then rec_EN=0 ->
  - wren_a/b high for exactly 3 single cycles;
  - addresses 0/16384, 1/16385, 2/16386 with matching data;
  - read pulses align with wren;
  - rec_done=1 and sample_len=3.
- Held read_ready: read_ready stuck high for 10 cycles -> exactly 3 writes (one per WRITE-GAP-CAPTURE loop), never back-to-back wren.
- Full RAM: feed 16384 frames with rec_EN held high -> last write at address_a=16383 / address_b=32767, then DONE; further read_ready produces no read and no wren; sample_len=16384.
- Reset mid-take: clear_b low during the WRITE cycle of frame 5 -> wren drops asynchronously, state IDLE, sample_len=0.
- Trigger (SAMPLE_RECORDER_TRIGGER_EN defined): frames with |L|,|R| < 4096, then L=-24'd5000 -> earlier frames popped (read pulses) but not written; the -5000 frame is written at address 0 and sample_len=1.
